addsub_cmp_pipe: RTL and testbench
==================================

Name: addsub_cmp_pipe

Overview:
Parametrised, pipelined successor to the implicit adder, subtractor and comparator test blocks, merged into one unit.
- Performs add, subtract, unsigned compare (A<=B) or signed compare (A<=B), selected per transaction.
- Carry chain is split into CHUNK-bit slices, one slice per pipeline stage, with a valid/ready handshake and full backpressure.
- Used as a carry-chain mapping and pipelining stress design for the QLF flow.

Parameters:
WIDTH, 16, operand width in bits (>=1).
CHUNK, 4, bits of carry chain resolved per stage (1..WIDTH).
NSTAGES, derived = ceil(WIDTH/CHUNK), pipeline depth (not overridable).

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operand/mode beat valid.
in_ready  output  1  unit can accept a beat this cycle.
mode  input  2  00 add, 01 sub, 10 unsigned LE, 11 signed LE.
A  input  WIDTH  operand A.
B  input  WIDTH  operand B.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.
S  output  WIDTH+1  arithmetic result.
CO  output  1  compare result.

Behaviour:
- Reset: rst_n low asynchronously clears all stage valid bits, out_valid=0, S=0, CO=0. Data registers may also clear. Release is synchronous to clk.
- Reset mid-operation: every in-flight beat is discarded. No output is produced for it after release.
- Global advance: advance = !out_valid | out_ready. in_ready = advance. Combinational from out_valid/out_ready only, never from in_valid.
- Accept: the beat is captured when in_valid & in_ready at a rising edge. When advance=0, all stages hold, including data, mode and valid bits.
- Stage k (0..NSTAGES-1) resolves bits [k*CHUNK +: CHUNK] using the carry registered by stage k-1. The stage 0 carry-in is 0 for add and 1 for sub/compare. Unresolved operand slices travel with the beat.
- Latency: a beat accepted at edge t has out_valid=1 after edge t+NSTAGES if no stall occurs. Throughput is 1 beat/cycle.
- Ordering is strictly in order. There are no bubbles beyond those caused by in_valid=0.
- Add: S = {1'b0,A} + {1'b0,B}. S[WIDTH] is the carry-out. CO=0.
- Sub: S = ({1'b0,A} - {1'b0,B}) mod 2^(WIDTH+1). S[WIDTH]=1 iff A<B unsigned. CO=0.
- Unsigned LE (mode 10): compute B + ~A + 1 internally. CO = carry-out (1 iff A<=B). S=0.
- Signed LE (mode 11): operands are two's complement. CO = 1 iff $signed(A) <= $signed(B), computed as carry-out XOR (A[W-1]^B[W-1]). S=0.
- Last slice width is WIDTH - (NSTAGES-1)*CHUNK and may be narrower than CHUNK.
- Boundary cases:
  - CHUNK=WIDTH gives NSTAGES=1 (single register stage).
  - WIDTH=1 is legal.
  - All-ones add wraps into S[WIDTH] correctly.
  - A=B gives CO=1 in both compare modes.
- Output hold: S, CO and out_valid are stable while out_valid & !out_ready. If in_valid is sampled while in_ready=0, there is no effect.

Test Plan:
- WIDTH=8, CHUNK=4; mode 00, A=0xFF, B=0x01 at edge t -> out_valid at t+2, S=0x100, CO=0.
- Mode 01, A=0x05, B=0x07 -> S=0x1FE, CO=0; then A=0x07, B=0x05 -> S=0x002.
- Mode 10 with A=0x80, B=0x7F -> CO=0. Mode 11 with the same operands -> CO=1 (-128<=127). A=B=0x3C in both modes -> CO=1, S=0.
- Back-to-back 20 random beats, out_ready toggled pseudo-randomly -> results in order and match the reference model. in_ready=0 exactly when out_valid & !out_ready. No beat is lost or duplicated.
- Pull rst_n low for 1 cycle mid-stream with 2 beats in flight -> out_valid=0, S=0, CO=0 immediately (async). No stale result after release. The next beat has full latency.
- WIDTH=10, CHUNK=4 (3 stages, 2-bit last slice) and WIDTH=8, CHUNK=8: add 0x3FF+0x001 -> S=0x400 after 3 cycles; add 0xFF+0xFF -> S=0x1FE after 1 cycle.

Source files
------------

// File: rtl/addsub_cmp_pipe.sv
// addsub_cmp_pipe
//   Pipelined add / subtract / unsigned-LE / signed-LE unit. The carry chain
//   is broken into CHUNK-bit slices, one slice resolved per pipeline stage.
//   A single global advance signal gives a valid/ready handshake with full
//   backpressure: when the output is held, every stage holds.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand beat valid
//   in_ready   out  beat accepted this cycle (= advance)
//   mode       in   00 add, 01 sub, 10 unsigned A<=B, 11 signed A<=B
//   A, B       in   operands, WIDTH bits
//   out_valid  out  result valid
//   out_ready  in   downstream accepts result
//   S          out  arithmetic result, WIDTH+1 bits (0 for compares)
//   CO         out  compare result (0 for add/sub)
module addsub_cmp_pipe #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   S,
  output logic             CO
);

  localparam int NSTAGES = (WIDTH + CHUNK - 1) / CHUNK;
  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  // x/y are the already-conditioned addends (operand inversion done at
  // capture), sum collects resolved slices, c is the carry into the next
  // unresolved slice. sdiff remembers A[msb]^B[msb] for the signed compare.
  typedef struct packed {
    logic             v;
    logic [1:0]       mode;
    logic             sdiff;
    logic             c;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] sum;
  } stage_t;

  // st_q[0] is the capture register; st_q[k+1] holds the beat after slice k
  // has been resolved, so st_q[NSTAGES] is the output register.
  stage_t st_q [0:NSTAGES];
  stage_t st_d [0:NSTAGES];

  logic advance;

  assign advance   = !st_q[NSTAGES].v | out_ready;
  assign in_ready  = advance;
  assign out_valid = st_q[NSTAGES].v;

  always_comb begin
    logic [WIDTH:0] m;
    logic [WIDTH:0] xs;
    logic [WIDTH:0] ys;
    logic [WIDTH:0] t;
    logic [WIDTH:0] tc;
    int             lo;
    int             sw;

    m  = '0;
    xs = '0;
    ys = '0;
    t  = '0;
    tc = '0;
    lo = 0;
    sw = 0;

    st_d[0]       = '0;
    st_d[0].v     = in_valid;
    st_d[0].mode  = mode;
    st_d[0].sdiff = A[WIDTH-1] ^ B[WIDTH-1];
    case (mode)
      2'b00: begin
        st_d[0].x = A;
        st_d[0].y = B;
        st_d[0].c = 1'b0;
      end
      2'b01: begin
        st_d[0].x = A;
        st_d[0].y = ~B;
        st_d[0].c = 1'b1;
      end
      default: begin
        // compares evaluate B - A so the carry-out means A <= B
        st_d[0].x = B;
        st_d[0].y = ~A;
        st_d[0].c = 1'b1;
      end
    endcase

    for (int k = 0; k < NSTAGES; k++) begin
      lo = k * CHUNK;
      sw = (WIDTH - lo < CHUNK) ? (WIDTH - lo) : CHUNK;
      m  = (ONE << sw) - ONE;
      xs = ({1'b0, st_q[k].x} >> lo) & m;
      ys = ({1'b0, st_q[k].y} >> lo) & m;
      t  = xs + ys + {{WIDTH{1'b0}}, st_q[k].c};
      tc = t >> sw;
      st_d[k+1]     = st_q[k];
      st_d[k+1].sum = (st_q[k].sum & ~(m[WIDTH-1:0] << lo))
                    | ((t[WIDTH-1:0] & m[WIDTH-1:0]) << lo);
      st_d[k+1].c   = tc[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NSTAGES; i++) begin
        st_q[i] <= '0;
      end
    end else if (advance) begin
      for (int i = 0; i <= NSTAGES; i++) begin
        st_q[i] <= st_d[i];
      end
    end
  end

  always_comb begin
    S  = '0;
    CO = 1'b0;
    if (st_q[NSTAGES].v) begin
      case (st_q[NSTAGES].mode)
        2'b00:   S  = {st_q[NSTAGES].c, st_q[NSTAGES].sum};
        // carry-out of A + ~B + 1 is "no borrow", so bit WIDTH is its inverse
        2'b01:   S  = {~st_q[NSTAGES].c, st_q[NSTAGES].sum};
        2'b10:   CO = st_q[NSTAGES].c;
        default: CO = st_q[NSTAGES].c ^ st_q[NSTAGES].sdiff;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_cmp_pipe.sv
module tb_addsub_cmp_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance 0: WIDTH=8 CHUNK=4 (2 stages)
  logic       iv0, ir0, ov0, or0, co0;
  logic [1:0] m0;
  logic [7:0] a0, b0;
  logic [8:0] s0;
  // instance 1: WIDTH=10 CHUNK=4 (3 stages, 2-bit last slice)
  logic       iv1, ir1, ov1, or1, co1;
  logic [1:0] m1;
  logic [9:0] a1, b1;
  logic [10:0] s1;
  // instance 2: WIDTH=8 CHUNK=8 (1 stage)
  logic       iv2, ir2, ov2, or2, co2;
  logic [1:0] m2;
  logic [7:0] a2, b2;
  logic [8:0] s2;

  int checks = 0;
  int errors = 0;

  addsub_cmp_pipe #(.WIDTH(8), .CHUNK(4)) u_w8c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .mode(m0),
    .A(a0), .B(b0), .out_valid(ov0), .out_ready(or0), .S(s0), .CO(co0));

  addsub_cmp_pipe #(.WIDTH(10), .CHUNK(4)) u_w10c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .mode(m1),
    .A(a1), .B(b1), .out_valid(ov1), .out_ready(or1), .S(s1), .CO(co1));

  addsub_cmp_pipe #(.WIDTH(8), .CHUNK(8)) u_w8c8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .mode(m2),
    .A(a2), .B(b2), .out_valid(ov2), .out_ready(or2), .S(s2), .CO(co2));

  // reference for the 8-bit instance: returns {S, CO}
  function automatic logic [9:0] model8(input logic [1:0] m, input logic [7:0] a,
                                        input logic [7:0] b);
    logic [8:0] s;
    logic       co;
    s  = '0;
    co = 1'b0;
    case (m)
      2'b00:   s  = {1'b0, a} + {1'b0, b};
      2'b01:   s  = {1'b0, a} - {1'b0, b};
      2'b10:   co = (a <= b);
      default: co = ($signed(a) <= $signed(b));
    endcase
    return {s, co};
  endfunction

  task automatic set_in(input int w, input logic v, input logic [1:0] m,
                        input logic [15:0] a, input logic [15:0] b);
    case (w)
      0: begin iv0 = v; m0 = m; a0 = a[7:0]; b0 = b[7:0]; end
      1: begin iv1 = v; m1 = m; a1 = a[9:0]; b1 = b[9:0]; end
      default: begin iv2 = v; m2 = m; a2 = a[7:0]; b2 = b[7:0]; end
    endcase
  endtask

  task automatic set_ready(input int w, input logic r);
    case (w)
      0: or0 = r;
      1: or1 = r;
      default: or2 = r;
    endcase
  endtask

  task automatic get_out(input int w, output logic ov, output logic [16:0] s,
                         output logic co);
    s = '0;
    case (w)
      0: begin ov = ov0; s[8:0] = s0; co = co0; end
      1: begin ov = ov1; s[10:0] = s1; co = co1; end
      default: begin ov = ov2; s[8:0] = s2; co = co2; end
    endcase
  endtask

  // one beat through instance w with out_ready held high; lat counts edges
  // after the accept edge until out_valid is seen (20 means it never came)
  task automatic xact(input int w, input logic [1:0] m, input logic [15:0] a,
                      input logic [15:0] b, output logic [16:0] s,
                      output logic co, output int lat);
    logic ov;
    @(negedge clk);
    set_ready(w, 1'b1);
    set_in(w, 1'b1, m, a, b);
    @(posedge clk);
    @(negedge clk);
    set_in(w, 1'b0, 2'b00, 16'h0, 16'h0);
    lat = 0;
    get_out(w, ov, s, co);
    while (!ov && lat < 20) begin
      @(negedge clk);
      lat++;
      get_out(w, ov, s, co);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({ov0, s0, co0} !== 11'h0) begin
      errors++;
      $display("FAIL reset_w8c4: ov,S,CO got %b,%h,%b want 0,000,0", ov0, s0, co0);
    end
    checks++;
    if (ir0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", ir0);
    end
    checks++;
    if ({ov1, s1, co1, ov2, s2, co2} !== 24'h0) begin
      errors++;
      $display("FAIL reset_others: ov1=%b S1=%h ov2=%b S2=%h want zeros", ov1, s1, ov2, s2);
    end
  endtask

  task automatic test_add();
    logic [16:0] s;
    logic        co;
    int          lat;
    xact(0, 2'b00, 16'hFF, 16'h01, s, co, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL add_latency: got %0d want 2", lat); end
    checks++;
    if (s !== 17'h100 || co !== 1'b0) begin
      errors++; $display("FAIL add_ff_01: S=%h CO=%b want 100,0", s, co);
    end
    xact(0, 2'b00, 16'h12, 16'h34, s, co, lat);
    checks++;
    if (s !== 17'h046 || co !== 1'b0) begin
      errors++; $display("FAIL add_12_34: S=%h CO=%b want 046,0", s, co);
    end
  endtask

  task automatic test_sub();
    logic [16:0] s;
    logic        co;
    int          lat;
    xact(0, 2'b01, 16'h05, 16'h07, s, co, lat);
    checks++;
    if (s !== 17'h1FE || co !== 1'b0) begin
      errors++; $display("FAIL sub_05_07: S=%h CO=%b want 1fe,0", s, co);
    end
    xact(0, 2'b01, 16'h07, 16'h05, s, co, lat);
    checks++;
    if (s !== 17'h002 || co !== 1'b0) begin
      errors++; $display("FAIL sub_07_05: S=%h CO=%b want 002,0", s, co);
    end
  endtask

  task automatic test_compare();
    logic [16:0] s;
    logic        co;
    int          lat;
    xact(0, 2'b10, 16'h80, 16'h7F, s, co, lat);
    checks++;
    if (co !== 1'b0 || s !== 17'h0) begin
      errors++; $display("FAIL ule_80_7f: CO=%b S=%h want 0,000", co, s);
    end
    xact(0, 2'b11, 16'h80, 16'h7F, s, co, lat);
    checks++;
    if (co !== 1'b1 || s !== 17'h0) begin
      errors++; $display("FAIL sle_80_7f: CO=%b S=%h want 1,000", co, s);
    end
    xact(0, 2'b10, 16'h3C, 16'h3C, s, co, lat);
    checks++;
    if (co !== 1'b1 || s !== 17'h0) begin
      errors++; $display("FAIL ule_eq: CO=%b S=%h want 1,000", co, s);
    end
    xact(0, 2'b11, 16'h3C, 16'h3C, s, co, lat);
    checks++;
    if (co !== 1'b1 || s !== 17'h0) begin
      errors++; $display("FAIL sle_eq: CO=%b S=%h want 1,000", co, s);
    end
    xact(0, 2'b11, 16'h7F, 16'h80, s, co, lat);
    checks++;
    if (co !== 1'b0) begin
      errors++; $display("FAIL sle_7f_80: CO=%b want 0", co);
    end
    xact(0, 2'b10, 16'h7F, 16'h80, s, co, lat);
    checks++;
    if (co !== 1'b1) begin
      errors++; $display("FAIL ule_7f_80: CO=%b want 1", co);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0]  exp_q[$];
    logic [9:0]  e;
    logic [31:0] r;
    int          sent;
    int          got;
    int          cyc;
    logic        pend;
    int          rdy_err;
    sent = 0; got = 0; cyc = 0; pend = 1'b0; rdy_err = 0;
    while (got < 20 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      r = $urandom;
      or0 = r[0];
      if (!pend && sent < 20) begin
        r = $urandom;
        iv0 = 1'b1; m0 = r[1:0]; a0 = r[15:8]; b0 = r[23:16];
        pend = 1'b1;
      end
      #1;
      checks++;
      if (ir0 !== !(ov0 && !or0)) begin
        errors++;
        $display("FAIL b2b_in_ready: cycle %0d got %b ov=%b or=%b", cyc, ir0, ov0, or0);
      end
      if (ov0 && or0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_beat: S=%h CO=%b with nothing expected", s0, co0);
        end else begin
          e = exp_q.pop_front();
          if ({s0, co0} !== e) begin
            errors++;
            $display("FAIL b2b_result %0d: S,CO got %h,%b want %h,%b", got, s0, co0, e[9:1], e[0]);
          end
        end
        got++;
      end
      if (iv0 && ir0) begin
        exp_q.push_back(model8(m0, a0, b0));
        sent++;
        pend = 1'b0;
      end
      @(posedge clk);
      #1;
      if (!pend) iv0 = 1'b0;
    end
    iv0 = 1'b0;
    or0 = 1'b1;
    checks++;
    if (got !== 20 || sent !== 20 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL b2b_count: sent %0d got %0d left %0d want 20,20,0", sent, got, exp_q.size());
    end
    if (rdy_err != 0) errors++;
  endtask

  task automatic test_reset_midstream();
    logic [16:0] s;
    logic        co;
    int          lat;
    int          stale;
    @(negedge clk);
    or0 = 1'b0;
    iv0 = 1'b1; m0 = 2'b00; a0 = 8'hF0; b0 = 8'h20;
    @(posedge clk);
    @(negedge clk);
    m0 = 2'b01; a0 = 8'h10; b0 = 8'h01;
    @(posedge clk);
    @(negedge clk);
    iv0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ov0 !== 1'b1 || s0 !== 9'h110) begin
      errors++; $display("FAIL rst_pre: ov=%b S=%h want 1,110", ov0, s0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ov0, s0, co0} !== 11'h0) begin
      errors++; $display("FAIL rst_async: ov,S,CO got %b,%h,%b want 0,000,0", ov0, s0, co0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    or0 = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (ov0 !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++; $display("FAIL rst_stale: out_valid high %0d cycles after release want 0", stale);
    end
    xact(0, 2'b00, 16'h21, 16'h43, s, co, lat);
    checks++;
    if (lat !== 2 || s !== 17'h064) begin
      errors++; $display("FAIL rst_next_beat: lat=%0d S=%h want 2,064", lat, s);
    end
  endtask

  task automatic test_params();
    logic [16:0] s;
    logic        co;
    int          lat;
    xact(1, 2'b00, 16'h3FF, 16'h001, s, co, lat);
    checks++;
    if (lat !== 3 || s !== 17'h400 || co !== 1'b0) begin
      errors++; $display("FAIL w10_add: lat=%0d S=%h CO=%b want 3,400,0", lat, s, co);
    end
    xact(1, 2'b01, 16'h000, 16'h001, s, co, lat);
    checks++;
    if (s !== 17'h7FF) begin
      errors++; $display("FAIL w10_sub: S=%h want 7ff", s);
    end
    xact(1, 2'b11, 16'h200, 16'h1FF, s, co, lat);
    checks++;
    if (co !== 1'b1 || s !== 17'h0) begin
      errors++; $display("FAIL w10_sle: CO=%b S=%h want 1,000", co, s);
    end
    xact(1, 2'b10, 16'h200, 16'h1FF, s, co, lat);
    checks++;
    if (co !== 1'b0) begin
      errors++; $display("FAIL w10_ule: CO=%b want 0", co);
    end
    xact(2, 2'b00, 16'hFF, 16'hFF, s, co, lat);
    checks++;
    if (lat !== 1 || s !== 17'h1FE) begin
      errors++; $display("FAIL w8c8_add: lat=%0d S=%h want 1,1fe", lat, s);
    end
    xact(2, 2'b11, 16'hFF, 16'h00, s, co, lat);
    checks++;
    if (co !== 1'b1) begin
      errors++; $display("FAIL w8c8_sle: CO=%b want 1", co);
    end
    xact(2, 2'b10, 16'hFF, 16'h00, s, co, lat);
    checks++;
    if (co !== 1'b0) begin
      errors++; $display("FAIL w8c8_ule: CO=%b want 0", co);
    end
  endtask

  initial begin
    iv0 = 1'b0; m0 = 2'b00; a0 = '0; b0 = '0; or0 = 1'b1;
    iv1 = 1'b0; m1 = 2'b00; a1 = '0; b1 = '0; or1 = 1'b1;
    iv2 = 1'b0; m2 = 2'b00; a2 = '0; b2 = '0; or2 = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_add();
    test_sub();
    test_compare();
    test_back_to_back();
    test_reset_midstream();
    test_params();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
